// File: rtl/decode_id_stage.sv
// Instruction-decode stage of the 5-stage R2000 pipeline.
// Holds the register file, decodes control, resolves branches/jumps in ID,
// detects load-use and branch-operand hazards and feeds the ID/EX register.
module decode_id_stage #(
    parameter int DW             = 32,
    parameter bit EXC_ILLEGAL_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   inst_in,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          mem_wr_en,
    input  logic [4:0]    mem_wr_addr,
    output logic          hold_pc,
    output logic          hold_if,
    output logic          br,
    output logic [31:0]   pc_branch,
    output logic          except,
    output logic [31:0]   ex_pc,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_dest,
    output logic [3:0]    ex_alu_op,
    output logic          ex_alu_src,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_reg_write,
    output logic          ex_mem_to_reg,
    output logic          ex_valid
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                           OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03,
                           F_JR   = 6'h08, F_SYS  = 6'h0C, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
                           F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26,
                           F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_ADDU = 4'd1,  ALU_SUB = 4'd2,
                           ALU_SUBU = 4'd3, ALU_AND  = 4'd4,  ALU_OR  = 4'd5,
                           ALU_XOR = 4'd6,  ALU_NOR  = 4'd7,  ALU_SLT = 4'd8,
                           ALU_SLTU = 4'd9, ALU_SLL  = 4'd10, ALU_SRL = 4'd11,
                           ALU_SRA = 4'd12, ALU_LUI  = 4'd13;

    typedef struct packed {
        logic [31:0]   pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dest;
        logic [3:0]    alu_op;
        logic          alu_src;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          mem_to_reg;
        logic          valid;
    } idex_t;

    logic [DW-1:0] rf_q [32];
    logic [DW-1:0] rf_d [32];
    idex_t         idex_q, idex_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target;

    assign opcode = inst_in[31:26];
    assign rs     = inst_in[25:21];
    assign rt     = inst_in[20:16];
    assign rd     = inst_in[15:11];
    assign shamt  = inst_in[10:6];
    assign funct  = inst_in[5:0];
    assign imm16  = inst_in[15:0];
    assign target = inst_in[25:0];

    logic          legal, is_shift, is_jr, is_sys, is_beq, is_bne, is_j, is_lui;
    logic          writes_rd, writes_rt, alu_src, mem_read, mem_write;
    logic [3:0]    alu_op;
    logic [DW-1:0] imm_ext;
    logic          rs_used, rt_used, ctl_xfer;
    logic [4:0]    dest;
    logic          reg_write;
    logic [DW-1:0] rs_val, rt_val;
    logic          ex_hit, mem_hit, stall;
    logic          taken, bubble;

    // Instruction decode: classify the opcode/funct and build the immediate.
    always_comb begin
        legal     = 1'b0;
        is_shift  = 1'b0;
        is_jr     = 1'b0;
        is_sys    = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_lui    = 1'b0;
        writes_rd = 1'b0;
        writes_rt = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = ALU_ADD;
        imm_ext   = {{(DW-16){imm16[15]}}, imm16};
        case (opcode)
            OP_RTYPE: begin
                imm_ext = {{(DW-5){1'b0}}, shamt};
                case (funct)
                    F_ADD:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_ADD;  end
                    F_ADDU: begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_ADDU; end
                    F_SUB:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_SUB;  end
                    F_SUBU: begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_SUBU; end
                    F_AND:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_AND;  end
                    F_OR:   begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_OR;   end
                    F_XOR:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_XOR;  end
                    F_NOR:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_NOR;  end
                    F_SLT:  begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_SLT;  end
                    F_SLTU: begin legal = 1'b1; writes_rd = 1'b1; alu_op = ALU_SLTU; end
                    F_SLL:  begin legal = 1'b1; writes_rd = 1'b1; is_shift = 1'b1; alu_op = ALU_SLL; end
                    F_SRL:  begin legal = 1'b1; writes_rd = 1'b1; is_shift = 1'b1; alu_op = ALU_SRL; end
                    F_SRA:  begin legal = 1'b1; writes_rd = 1'b1; is_shift = 1'b1; alu_op = ALU_SRA; end
                    F_JR:   begin legal = 1'b1; is_jr  = 1'b1; end
                    F_SYS:  begin legal = 1'b1; is_sys = 1'b1; end
                    default: ;
                endcase
            end
            OP_J:     begin legal = 1'b1; is_j   = 1'b1; end
            OP_BEQ:   begin legal = 1'b1; is_beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:   begin legal = 1'b1; is_bne = 1'b1; alu_op = ALU_SUB; end
            OP_ADDI:  begin legal = 1'b1; writes_rt = 1'b1; alu_src = 1'b1; alu_op = ALU_ADD;  end
            OP_ADDIU: begin legal = 1'b1; writes_rt = 1'b1; alu_src = 1'b1; alu_op = ALU_ADDU; end
            OP_SLTI:  begin legal = 1'b1; writes_rt = 1'b1; alu_src = 1'b1; alu_op = ALU_SLT;  end
            OP_SLTIU: begin legal = 1'b1; writes_rt = 1'b1; alu_src = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI, OP_ORI, OP_XORI: begin
                legal     = 1'b1;
                writes_rt = 1'b1;
                alu_src   = 1'b1;
                alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                imm_ext        = '0;
                imm_ext[15:0]  = imm16;
            end
            OP_LUI: begin
                legal          = 1'b1;
                is_lui         = 1'b1;
                writes_rt      = 1'b1;
                alu_src        = 1'b1;
                alu_op         = ALU_LUI;
                imm_ext        = '0;
                imm_ext[31:16] = imm16;
            end
            OP_LW: begin legal = 1'b1; writes_rt = 1'b1; alu_src = 1'b1; mem_read  = 1'b1; end
            OP_SW: begin legal = 1'b1; alu_src = 1'b1; mem_write = 1'b1; end
            default: ;
        endcase
    end

    // Source usage, destination selection and control-transfer classification.
    always_comb begin
        rs_used   = !(is_shift || is_lui || is_j);
        rt_used   = (opcode == OP_RTYPE) || mem_write || is_beq || is_bne;
        ctl_xfer  = is_beq || is_bne || is_j || is_jr;
        dest      = writes_rd ? rd : (writes_rt ? rt : 5'd0);
        reg_write = (writes_rd || writes_rt) && (dest != 5'd0);
    end

    // Register file reads with write-through bypass from write-back.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0) rs_val = (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
        if (rt != 5'd0) rt_val = (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
    end

    // Register file next state; r0 is never written.
    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
    end

    // Hazard detection against the instruction in EX and the one in MEM.
    always_comb begin
        ex_hit  = (idex_q.dest != 5'd0) &&
                  ((rs_used && rs == idex_q.dest) || (rt_used && rt == idex_q.dest));
        mem_hit = mem_wr_en && (mem_wr_addr != 5'd0) &&
                  ((rs_used && rs == mem_wr_addr) || (rt_used && rt == mem_wr_addr));
        stall   = (idex_q.mem_read && ex_hit) ||
                  ((is_beq || is_bne || is_jr) && ((idex_q.reg_write && ex_hit) || mem_hit));
    end

    // Branch/jump resolution and exception raise; both suppressed while stalled.
    always_comb begin
        taken     = !stall && ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) ||
                               is_j || is_jr);
        pc_branch = pc_in;
        if (taken) begin
            if (is_j)
                pc_branch = {pc_in[31:28], target, 2'b00};
            else if (is_jr)
                pc_branch = rs_val[31:0];
            else
                pc_branch = pc_in + {{14{imm16[15]}}, imm16, 2'b00};
        end
        except  = !stall && (is_sys || (EXC_ILLEGAL_EN && !legal));
        br      = taken;
        hold_pc = stall;
        hold_if = stall;
        bubble  = stall || ctl_xfer || except;
    end

    // ID/EX next value: a decoded instruction, or an all-zero bubble.
    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.pc         = pc_in;
            idex_d.rs_data    = rs_val;
            idex_d.rt_data    = rt_val;
            idex_d.imm        = imm_ext;
            idex_d.rs         = rs;
            idex_d.rt         = rt;
            idex_d.dest       = dest;
            idex_d.alu_op     = alu_op;
            idex_d.alu_src    = alu_src;
            idex_d.mem_read   = mem_read;
            idex_d.mem_write  = mem_write;
            idex_d.reg_write  = reg_write;
            idex_d.mem_to_reg = mem_read;
            idex_d.valid      = 1'b1;
        end
    end

    // State registers: register file and ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            idex_q <= '0;
        end else begin
            rf_q   <= rf_d;
            idex_q <= idex_d;
        end
    end

    assign ex_pc         = idex_q.pc;
    assign ex_rs_data    = idex_q.rs_data;
    assign ex_rt_data    = idex_q.rt_data;
    assign ex_imm        = idex_q.imm;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_dest       = idex_q.dest;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_to_reg = idex_q.mem_to_reg;
    assign ex_valid      = idex_q.valid;

endmodule

// File: tb/tb_decode_id_stage.sv
// Testbench for decode_id_stage: directed scenarios followed by random
// instruction streams, checked against a behavioural pipeline model.
module tb_decode_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0, inst_in = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mem_wr_en = 1'b0;
    logic [4:0]  mem_wr_addr = '0;

    logic        hold_pc, hold_if, br, except;
    logic [31:0] pc_branch, ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_valid;

    decode_id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .hold_pc(hold_pc), .hold_if(hold_if), .br(br), .pc_branch(pc_branch),
        .except(except), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers and what sits in EX.
    logic [31:0] regs [32];
    logic [4:0]  m_ex_dest;
    logic        m_ex_mr, m_ex_rw;
    logic [5:0]  r_fns [10];
    logic [5:0]  i_ops [7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        m_ex_dest = '0;
        m_ex_mr   = 1'b0;
        m_ex_rw   = 1'b0;
    endtask

    function automatic logic [31:0] r_enc(input logic [5:0] fn, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic bit hit(input logic [4:0] a, input logic [4:0] s, input logic [4:0] t,
                               input bit us, input bit ut);
        return (a != 5'd0) && ((us && a == s) || (ut && a == t));
    endfunction

    // One ID cycle: drive, check fetch controls mid-cycle, clock, check ID/EX.
    task automatic step(input logic [31:0] pc, input logic [31:0] inst,
                        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic me, input logic [4:0] ma, output bit stalled);
        logic [5:0]  op, fn;
        logic [4:0]  s, t, d, dst;
        logic [31:0] sv, tv, imm, tgt;
        bit rtype, legal, shift, jr, sys, beq, bne, jmp, lw, sw, us, ut, writes;
        bit stl, take, exc, bub, rw;
        op = inst[31:26]; fn = inst[5:0];
        s = inst[25:21]; t = inst[20:16]; d = inst[15:11];
        rtype = (op == 6'h00);
        legal = rtype ? (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0C})
                      : (op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                    6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B});
        shift = rtype && (fn inside {6'h00, 6'h02, 6'h03});
        jr  = rtype && fn == 6'h08;
        sys = rtype && fn == 6'h0C;
        beq = op == 6'h04; bne = op == 6'h05; jmp = op == 6'h02;
        lw  = op == 6'h23; sw  = op == 6'h2B;
        us  = !(shift || op == 6'h0F || jmp);
        ut  = rtype || sw || beq || bne;
        writes = legal && (rtype ? !(jr || sys) : (op inside {[6'h08:6'h0F], 6'h23}));
        dst = writes ? (rtype ? d : t) : 5'd0;
        rw  = writes && dst != 5'd0;
        sv = (s == 0) ? 32'h0 : ((wbe && wba == s) ? wbd : regs[s]);
        tv = (t == 0) ? 32'h0 : ((wbe && wba == t) ? wbd : regs[t]);
        stl = (m_ex_mr && hit(m_ex_dest, s, t, us, ut)) ||
              ((beq || bne || jr) && ((m_ex_rw && hit(m_ex_dest, s, t, us, ut)) ||
                                      (me && hit(ma, s, t, us, ut))));
        take = !stl && ((beq && sv == tv) || (bne && sv != tv) || jmp || jr);
        if (!take) tgt = pc;
        else if (jmp) tgt = {pc[31:28], inst[25:0], 2'b00};
        else if (jr) tgt = sv;
        else tgt = pc + 32'(signed'(inst[15:0])) * 4;
        exc = !stl && (sys || !legal);
        bub = stl || beq || bne || jmp || jr || exc;
        if (shift) imm = {27'h0, inst[10:6]};
        else if (op inside {6'h0C, 6'h0D, 6'h0E}) imm = {16'h0, inst[15:0]};
        else if (op == 6'h0F) imm = {inst[15:0], 16'h0};
        else imm = 32'(signed'(inst[15:0]));

        pc_in = pc; inst_in = inst; wb_en = wbe; wb_addr = wba; wb_data = wbd;
        mem_wr_en = me; mem_wr_addr = ma;
        #4;
        chk("hold_pc", hold_pc, stl);
        chk("hold_if", hold_if, stl);
        chk("br", br, take);
        chk("pc_branch", pc_branch, tgt);
        chk("except", except, exc);
        @(posedge clk);
        if (wbe && wba != 0) regs[wba] = wbd;
        m_ex_mr   = !bub && lw;
        m_ex_rw   = !bub && rw;
        m_ex_dest = bub ? 5'd0 : dst;
        #1;
        chk("ex_valid", ex_valid, !bub);
        chk("ex_reg_write", ex_reg_write, !bub && rw);
        chk("ex_mem_read", ex_mem_read, !bub && lw);
        chk("ex_mem_to_reg", ex_mem_to_reg, !bub && lw);
        chk("ex_mem_write", ex_mem_write, !bub && sw);
        if (!bub) begin
            chk("ex_dest", ex_dest, dst);
            chk("ex_rs", ex_rs, s);
            chk("ex_rt", ex_rt, t);
            chk("ex_rs_data", ex_rs_data, sv);
            chk("ex_rt_data", ex_rt_data, tv);
            chk("ex_pc", ex_pc, pc);
            chk("ex_alu_src", ex_alu_src, !rtype);
            if (!rtype || shift) chk("ex_imm", ex_imm, imm);
        end
        stalled = stl;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0]  a, b, c, sh;
        logic [15:0] im;
        logic [5:0]  fn;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        sh = 5'($urandom_range(0, 31));
        im = 16'($urandom);
        case ($urandom_range(0, 11))
            0, 1, 2: return r_enc(r_fns[$urandom_range(0, 9)], a, b, c);
            3: begin
                fn = ($urandom_range(0, 2) == 0) ? 6'h00 : (($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03);
                return {6'h00, 5'h00, b, c, sh, fn};
            end
            4: return r_enc(6'h08, a, 5'd0, 5'd0);
            5: return 32'h0000_000C;
            6, 7: return i_enc(i_ops[$urandom_range(0, 6)], a, b, im);
            8: return i_enc(($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B, a, b, im);
            9: return i_enc(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, a, b, im);
            10: return i_enc(6'h0F, 5'd0, b, im);
            default: return ($urandom_range(0, 1) == 0) ? {6'h02, 26'($urandom)} : {6'h3F, 26'($urandom)};
        endcase
    endfunction

    initial begin
        bit          st;
        logic [31:0] ri, pc_r;
        logic        me_r, wbe_r, sv_rw, inj;
        logic [4:0]  ma_r, wba_r, sv_d;
        r_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        i_ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
        model_reset();

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_dest", ex_dest, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_hold_pc", hold_pc, 0);
        chk("rst_hold_if", hold_if, 0);
        chk("rst_br", br, 0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;

        // Register reads and write-through
        step(32'h100, r_enc(6'h20, 5'd5, 5'd0, 5'd6), 0, 0, 0, 0, 0, st);
        step(32'h104, r_enc(6'h20, 5'd3, 5'd0, 5'd4), 1, 5'd3, 32'hDEAD_BEEF, 0, 0, st);
        chk("wt_rs_data", ex_rs_data, 32'hDEAD_BEEF);
        chk("wt_dest", ex_dest, 4);
        chk("wt_reg_write", ex_reg_write, 1);
        step(32'h108, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, st);
        step(32'h10C, r_enc(6'h20, 5'd0, 5'd0, 5'd7), 1, 5'd0, 32'h1234_5678, 0, 0, st);
        chk("r0_stays_zero", ex_rs_data, 0);

        // Load-use
        step(32'h110, i_enc(6'h23, 5'd1, 5'd2, 16'h0), 0, 0, 0, 0, 0, st);
        step(32'h114, r_enc(6'h20, 5'd2, 5'd2, 5'd3), 0, 0, 0, 0, 0, st);
        step(32'h114, r_enc(6'h20, 5'd2, 5'd2, 5'd3), 0, 0, 0, 0, 0, st);

        // Branch taken / not taken
        step(32'h118, 32'h0, 1, 5'd1, 32'd7, 0, 0, st);
        step(32'h11C, 32'h0, 1, 5'd2, 32'd7, 0, 0, st);
        step(32'h40, i_enc(6'h04, 5'd1, 5'd2, 16'd3), 0, 0, 0, 0, 0, st);
        chk("beq_target", pc_branch, 32'h4C);
        step(32'h40, i_enc(6'h05, 5'd1, 5'd2, 16'd3), 0, 0, 0, 0, 0, st);

        // Branch-operand stall: EX match, MEM match, then write-back bypass
        step(32'h200, i_enc(6'h08, 5'd0, 5'd1, 16'd5), 0, 0, 0, 0, 0, st);
        step(32'h204, i_enc(6'h04, 5'd1, 5'd0, 16'd1), 0, 0, 0, 0, 0, st);
        step(32'h204, i_enc(6'h04, 5'd1, 5'd0, 16'd1), 0, 0, 0, 1, 5'd1, st);
        step(32'h204, i_enc(6'h04, 5'd1, 5'd0, 16'd1), 1, 5'd1, 32'd5, 0, 0, st);

        // Exceptions, immediate extension, jumps
        step(32'h300, 32'h0000_000C, 0, 0, 0, 0, 0, st);
        step(32'h304, {6'h3F, 26'h0}, 0, 0, 0, 0, 0, st);
        step(32'h308, i_enc(6'h0D, 5'd0, 5'd5, 16'h8000), 0, 0, 0, 0, 0, st);
        chk("ori_zext", ex_imm, 32'h0000_8000);
        step(32'h30C, i_enc(6'h08, 5'd0, 5'd6, 16'h8000), 0, 0, 0, 0, 0, st);
        chk("addi_sext", ex_imm, 32'hFFFF_8000);
        step(32'hA000_0310, {6'h02, 26'h123_4567}, 0, 0, 0, 0, 0, st);
        step(32'h314, r_enc(6'h08, 5'd1, 5'd0, 5'd0), 0, 0, 0, 0, 0, st);

        // Random instruction stream with an emulated EX->MEM->WB pipeline
        st = 0; me_r = 0; ma_r = 0; wbe_r = 0; wba_r = 0; ri = 0; pc_r = 0;
        repeat (400) begin
            if (!st) begin
                ri   = gen_inst();
                pc_r = $urandom & 32'hFFFF_FFFC;
            end
            inj = 1'b0;
            if (!wbe_r && $urandom_range(0, 3) == 0) begin
                inj = 1'b1;
                wba_r = 5'($urandom_range(0, 7));
            end
            sv_rw = m_ex_rw;
            sv_d  = m_ex_dest;
            step(pc_r, ri, wbe_r | inj, wba_r, $urandom, me_r, ma_r, st);
            wbe_r = me_r; wba_r = ma_r;
            me_r  = sv_rw; ma_r = sv_d;
        end

        // Reset in the middle of a load-use stall
        step(32'h400, 32'h0, 1, 5'd5, 32'h55, 0, 0, st);
        step(32'h404, i_enc(6'h23, 5'd1, 5'd2, 16'h0), 0, 0, 0, 0, 0, st);
        pc_in = 32'h408; inst_in = r_enc(6'h20, 5'd2, 5'd2, 5'd3);
        wb_en = 0; mem_wr_en = 0;
        #3;
        chk("stall_before_rst", hold_pc, 1);
        rst = 1'b0;
        #1;
        chk("midrst_hold_pc", hold_pc, 0);
        chk("midrst_hold_if", hold_if, 0);
        chk("midrst_ex_valid", ex_valid, 0);
        chk("midrst_ex_mem_read", ex_mem_read, 0);
        chk("midrst_ex_dest", ex_dest, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(32'h40C, r_enc(6'h20, 5'd5, 5'd0, 5'd6), 0, 0, 0, 0, 0, st);
        chk("r5_after_rst", ex_rs_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_id_stage.md
Name: decode_id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS R2000 pipeline. Sits directly downstream of the fetch stage and consumes its pc/instruction pair.
- Holds the 32x32 register file and decodes control signals. Resolves branches and jumps in ID, detects load-use and branch-operand hazards, and drives the fetch-stage hold, branch and exception controls.
- Registers all results into the ID/EX pipeline register feeding execute.

Parameters:
- DW, 32, datapath width
- EXC_ILLEGAL_EN, 1, raise except on unknown opcode/funct (0: decode as NOP)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  32  PC+4 of inst_in, from fetch stage
- inst_in  in  32  instruction from fetch stage
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- mem_wr_en  in  1  instruction in MEM will write a register
- mem_wr_addr  in  5  its destination
- hold_pc  out  1  freeze PC register (combinational)
- hold_if  out  1  freeze IF/ID register (combinational)
- br  out  1  redirect fetch (combinational)
- pc_branch  out  32  redirect target (combinational)
- except  out  1  syscall/illegal instruction (combinational)
- ex_pc  out  32  registered pc_in
- ex_rs_data, ex_rt_data  out  32 each  register operands
- ex_imm  out  32  extended immediate
- ex_rs, ex_rt, ex_dest  out  5 each  source/destination indices
- ex_alu_op  out  4  ALU function code
- ex_alu_src  out  1  1 = use ex_imm as operand B
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  control
- ex_valid  out  1  0 = bubble

Behaviour:
- Reset (rst=0, async): all 32 registers = 0; every ex_* output = 0 (bubble). Combinational outputs follow from the cleared state: hold_pc=hold_if=0; br/except driven by decode of inst_in. Reset mid-stall clears the stall immediately.
- Register file:
  - r0 reads 0 and is never written.
  - Write on rising edge when wb_en && wb_addr!=0.
  - Reads are combinational with write-through bypass: if wb_en && wb_addr==rs/rt && addr!=0, read wb_data.
- Decode set:
  - R-type: add addu sub subu and or xor nor slt sltu sll srl sra jr syscall(funct 0x0C).
  - I-type: addi addiu slti sltiu andi ori xori lui lw sw beq bne.
  - J-type: j.
  - Anything else is illegal.
- Immediate:
  - Sign-extend for arith, slti/sltiu, lw/sw, branches.
  - Zero-extend for andi/ori/xori.
  - lui: {imm,16'h0}.
  - Shifts: ex_imm = shamt zero-extended.
- Destination: ex_dest = rd for R-type, rt for I-type writers. ex_reg_write=0 for sw, beq, bne, j, jr, and when dest==0.
- Latency: 1 cycle; ID/EX updates every rising edge (no external stall input).
- Branch resolution (when not stalled):
  - beq/bne: compare bypassed rs/rt. Taken gives br=1 and pc_branch = pc_in + (sext(imm)<<2), 32-bit wrap.
  - j: br=1, pc_branch = {pc_in[31:28], target, 2'b00}.
  - jr: br=1, pc_branch = rs data.
  - Not taken: br=0, pc_branch = pc_in.
  - No delay slot: the fetch stage flushes on br.
- Control-transfer entry: beq, bne, j and jr enter ID/EX as a bubble (ex_valid=0, all control 0).
- Hazard stall: stall=1 when either condition holds.
  - (a) Load-use: ex_mem_read && ex_dest!=0 && ex_dest equals a source the instruction reads.
  - (b) beq/bne/jr source matches ex_dest with ex_reg_write, or matches mem_wr_addr with mem_wr_en (addr!=0).
- During stall:
  - hold_pc=hold_if=1.
  - br=0, except=0.
  - ID/EX loads a bubble.
  - Repeats each cycle until the condition clears.
- Exception: syscall, or illegal with EXC_ILLEGAL_EN=1, and not stalled:
  - except=1 for that cycle and ID/EX loads a bubble.
  - br and except are never asserted together.
- Source usage: rt counts as a source only for R-type, sw, beq and bne. rs is not a source for sll/srl/sra, lui or j.

Test Plan:
- Reset: rst low mid-run -> all ex_* = 0 and hold_pc=0 immediately; after release, read of r5 returns 0.
- Write-through: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF with inst_in=add r4,r3,r0 -> next edge ex_rs_data=0xDEADBEEF, ex_dest=4, ex_reg_write=1. A write to r0 keeps r0 at 0.
- Load-use: lw r2,0(r1) then add r3,r2,r2 -> one cycle with hold_pc=hold_if=1 and ex_valid=0, then add issues with ex_valid=1.
- Branch taken: r1=r2=7, pc_in=0x40, beq r1,r2,+3 -> br=1, pc_branch=0x4C, ex_valid=0 next edge. bne with the same operands -> br=0.
- Branch-operand stall: addi r1,r0,5 in EX, then beq r1,r0 -> two stall cycles (EX match, then MEM match); resolves once the write-back bypass supplies 5.
- Exceptions and extension: syscall -> except=1 with br=0. Opcode 0x3F -> except=1. ori imm 0x8000 -> ex_imm=0x00008000; addi imm 0x8000 -> ex_imm=0xFFFF8000.
